mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 The block SHALL have ports: inst_in  in  32  IR contents; zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete.
REQ-003 The block SHALL have ports: ALU_operation  out  3  ALU opcode (000 and, 001 or, 010 add, 110 sub, 100 nor, 111 slt, 101 srl, 011 xor).
REQ-004 The block SHALL have ports: ALUSrcA  out  1  (0 PC, 1 A); ALUSrcB  out  2  (00 B, 01 const 4, 10 imm, 11 sext imm<<2); ext_zero  out  1  imm zero-extend when 1, else sign-extend.
REQ-005 The block SHALL have ports: PCSource  out  2  (00 ALU result, 01 ALUOut, 10 jump target); pc_we  out  1  final PC write enable.
REQ-006 The block SHALL have ports: IorD  out  1; MemRead  out  1; MemWrite  out  1; IRWrite  out  1; RegWrite  out  1; RegDst  out  2  (00 rt, 01 rd, 10 $31); MemtoReg  out  2  (00 ALUOut, 01 MDR, 10 PC).
REQ-007 The block SHALL have ports: state_out  out  5  current state code; illegal  out  1  one-cycle pulse on unsupported instruction.

Function
REQ-008 State codes SHALL be: IF=0, ID=1, MA=2, MR=3, LWB=4, MW=5, REX=6, RWB=7, BR=8, J=9, IEX=10, IWB=11, JAL=12; all outputs are decoded from state, with mem_ready gating only where stated.
REQ-009 IF SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_operation=010, PCSource=00, IRWrite=pc_we=mem_ready, and SHALL hold in IF while mem_ready=0; on mem_ready=1 it SHALL go to ID.
REQ-010 ID SHALL drive ALUSrcA=0, ALUSrcB=11, ALU_operation=010, and SHALL go to the next state selected by inst_in[31:26]: 100011/101011->MA; 000000->REX; 000100/000101->BR; 000010->J; 000011->JAL; 001000/001100/001101/001110/001010->IEX; any other opcode->IF with illegal=1 for that cycle.
REQ-011 MA SHALL drive ALUSrcA=1, ALUSrcB=10, ext_zero=0, op=010, and SHALL go to MR for lw or MW for sw.
REQ-012 MR SHALL drive MemRead=1, IorD=1, hold until mem_ready=1, then go to LWB; LWB SHALL drive RegWrite=1, RegDst=00, MemtoReg=01, then go to IF.
REQ-013 MW SHALL drive MemWrite=1, IorD=1, hold until mem_ready=1, then go to IF.
REQ-014 REX SHALL drive ALUSrcA=1, ALUSrcB=00, op decoded from funct inst_in[5:0]: 100000->010, 100010->110, 100100->000, 100101->001, 100110->011, 100111->100, 101010->111, 000010->101; any other funct SHALL go to IF with illegal=1 and no register write.
REQ-015 RWB SHALL drive RegWrite=1, RegDst=01, MemtoReg=00, then go to IF.
REQ-016 BR SHALL drive ALUSrcA=1, ALUSrcB=00, op=110, PCSource=01, pc_we=zero for beq (000100) or ~zero for bne (000101), then go to IF.
REQ-017 J SHALL drive PCSource=10, pc_we=1, then go to IF; JAL SHALL additionally drive RegWrite=1, RegDst=10, MemtoReg=10.
REQ-018 IEX SHALL drive ALUSrcA=1, ALUSrcB=10, with op/ext_zero set as: addi 010/0, andi 000/1, ori 001/1, xori 011/1, slti 111/0; IWB SHALL drive RegWrite=1, RegDst=00, MemtoReg=00, then go to IF.
REQ-019 Every output not listed for a state SHALL be 0; ALU_operation SHALL default to 010.
REQ-020 Cycle counts with mem_ready held at 1 SHALL be: lw 5; sw, R-type and I-type 4; beq, bne, j and jal 3.

Reset
REQ-021 rst=1 SHALL force state IF asynchronously; all write enables (pc_we, IRWrite, MemWrite, RegWrite) SHALL fall to 0 immediately, and illegal SHALL be 0.
REQ-022 On rst deassertion the FSM SHALL start in IF on the next rising clk edge; rst asserted during any state, including a pending MR or MW wait, SHALL abandon the instruction with no further write.

Verification
REQ-023 lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=01 only in state 4.
REQ-024 add (funct 100000) -> states 0,1,6,7; ALU_operation=010 in state 6; RegWrite=1 with RegDst=01 in state 7.
REQ-025 beq with zero=1, then bne with zero=1 -> pc_we=1 for beq and pc_we=0 for bne in state 8; both return to IF after 3 cycles.
REQ-026 In IF, mem_ready=0 for 3 cycles then 1 -> state stays 0 for 3 cycles with IRWrite=pc_we=0, then IRWrite=pc_we=1 for exactly 1 cycle.
REQ-027 Opcode 111111 -> illegal=1 in state 1, next state 0, no RegWrite or MemWrite asserted.
REQ-028 rst pulsed mid-cycle while in MW with mem_ready=0 -> state_out=0 and MemWrite=0 without waiting for a clk edge.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: control FSM for a multi-cycle MIPS-style datapath.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   inst_in[31:0]     - instruction register contents (opcode/funct decode)
//   zero              - ALU zero flag, resolves beq/bne
//   mem_ready         - memory access complete, stalls IF/MR/MW
//   ALU_operation,
//   ALUSrcA, ALUSrcB,
//   ext_zero          - ALU operand/opcode selects and immediate extension
//   PCSource, pc_we   - PC next-value select and final PC write enable
//   IorD, MemRead,
//   MemWrite, IRWrite - memory address select, memory strobes, IR load
//   RegWrite, RegDst,
//   MemtoReg          - register-file write enable, dest and data selects
//   state_out         - current state code
//   illegal           - one-cycle pulse on an unsupported opcode/funct
module mcycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  ALU_operation,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ext_zero,
  output logic [1:0]  PCSource,
  output logic        pc_we,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [4:0]  state_out,
  output logic        illegal
);

  typedef enum logic [4:0] {
    S_IF  = 5'd0,
    S_ID  = 5'd1,
    S_MA  = 5'd2,
    S_MR  = 5'd3,
    S_LWB = 5'd4,
    S_MW  = 5'd5,
    S_REX = 5'd6,
    S_RWB = 5'd7,
    S_BR  = 5'd8,
    S_J   = 5'd9,
    S_IEX = 5'd10,
    S_IWB = 5'd11,
    S_JAL = 5'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state;
  state_t     next_state;
  logic [5:0] opcode;
  logic [5:0] funct;

  // Write strobes before reset gating
  logic pc_we_raw;
  logic ir_we_raw;
  logic mem_we_raw;
  logic reg_we_raw;
  logic illegal_raw;

  // Register fields and immediate are consumed by the datapath, not here
  logic unused_inst;

  assign opcode      = inst_in[31:26];
  assign funct       = inst_in[5:0];
  assign unused_inst = ^inst_in[25:6];
  assign state_out   = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    next_state    = state;
    ALU_operation = ALU_ADD;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ext_zero      = 1'b0;
    PCSource      = 2'b00;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    pc_we_raw     = 1'b0;
    ir_we_raw     = 1'b0;
    mem_we_raw    = 1'b0;
    reg_we_raw    = 1'b0;
    illegal_raw   = 1'b0;

    case (state)
      S_IF: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        ir_we_raw = mem_ready;
        pc_we_raw = mem_ready;
        if (mem_ready) next_state = S_ID;
      end
      S_ID: begin
        // Speculative branch target: PC + (sext imm << 2)
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    next_state = S_MA;
          OP_RTYPE:        next_state = S_REX;
          OP_BEQ, OP_BNE:  next_state = S_BR;
          OP_J:            next_state = S_J;
          OP_JAL:          next_state = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                           next_state = S_IEX;
          default: begin
            illegal_raw = 1'b1;
            next_state  = S_IF;
          end
        endcase
      end
      S_MA: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (opcode == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) next_state = S_LWB;
      end
      S_LWB: begin
        reg_we_raw = 1'b1;
        MemtoReg   = 2'b01;
        next_state = S_IF;
      end
      S_MW: begin
        mem_we_raw = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) next_state = S_IF;
      end
      S_REX: begin
        ALUSrcA    = 1'b1;
        next_state = S_RWB;
        case (funct)
          6'b100000: ALU_operation = ALU_ADD;
          6'b100010: ALU_operation = ALU_SUB;
          6'b100100: ALU_operation = ALU_AND;
          6'b100101: ALU_operation = ALU_OR;
          6'b100110: ALU_operation = ALU_XOR;
          6'b100111: ALU_operation = ALU_NOR;
          6'b101010: ALU_operation = ALU_SLT;
          6'b000010: ALU_operation = ALU_SRL;
          default: begin
            illegal_raw = 1'b1;
            next_state  = S_IF;
          end
        endcase
      end
      S_RWB: begin
        reg_we_raw = 1'b1;
        RegDst     = 2'b01;
        next_state = S_IF;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCSource      = 2'b01;
        if (opcode == OP_BEQ)      pc_we_raw = zero;
        else if (opcode == OP_BNE) pc_we_raw = ~zero;
        next_state = S_IF;
      end
      S_J: begin
        PCSource   = 2'b10;
        pc_we_raw  = 1'b1;
        next_state = S_IF;
      end
      S_JAL: begin
        PCSource   = 2'b10;
        pc_we_raw  = 1'b1;
        reg_we_raw = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        next_state = S_IF;
      end
      S_IEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_IWB;
        case (opcode)
          OP_ANDI: begin ALU_operation = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin ALU_operation = ALU_OR;  ext_zero = 1'b1; end
          OP_XORI: begin ALU_operation = ALU_XOR; ext_zero = 1'b1; end
          OP_SLTI: ALU_operation = ALU_SLT;
          default: ALU_operation = ALU_ADD;
        endcase
      end
      S_IWB: begin
        reg_we_raw = 1'b1;
        next_state = S_IF;
      end
      default: next_state = S_IF;
    endcase
  end

  // Reset kills every write strobe at once, even while IF sees mem_ready
  assign pc_we    = pc_we_raw   & ~rst;
  assign IRWrite  = ir_we_raw   & ~rst;
  assign MemWrite = mem_we_raw  & ~rst;
  assign RegWrite = reg_we_raw  & ~rst;
  assign illegal  = illegal_raw & ~rst;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: self-checking bench for mcycle_ctrl.
// Directed vector table with explicit state sequences, randomized instructions
// checked against an instruction-level reference model, and hand sequences for
// memory stalls and asynchronous reset.
module tb_mcycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_in;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  ALU_operation;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        ext_zero;
  logic [1:0]  PCSource;
  logic        pc_we;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [4:0]  state_out;
  logic        illegal;

  mcycle_ctrl dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .zero(zero), .mem_ready(mem_ready),
    .ALU_operation(ALU_operation), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ext_zero(ext_zero), .PCSource(PCSource), .pc_we(pc_we), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .state_out(state_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle trace of one instruction
  logic [4:0] t_st  [10];
  logic [2:0] t_op  [10];
  logic [1:0] t_rd  [10];
  logic [1:0] t_m2r [10];
  logic       t_ez  [10];
  logic [9:0] m_rw, m_mw, m_pc, m_ir, m_ill;
  int         n_cyc;

  // Run one instruction from IF back to IF with mem_ready=1 (bounded)
  task automatic exec(input logic [31:0] inst, input logic z);
    inst_in   = inst;
    zero      = z;
    mem_ready = 1'b1;
    n_cyc     = 0;
    m_rw = '0; m_mw = '0; m_pc = '0; m_ir = '0; m_ill = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      t_st[k]  = state_out;
      t_op[k]  = ALU_operation;
      t_rd[k]  = RegDst;
      t_m2r[k] = MemtoReg;
      t_ez[k]  = ext_zero;
      m_rw[k]  = RegWrite;
      m_mw[k]  = MemWrite;
      m_pc[k]  = pc_we;
      m_ir[k]  = IRWrite;
      m_ill[k] = illegal;
      n_cyc    = k + 1;
      @(posedge clk);
      #1;
      if (state_out == 5'd0) break;
    end
  endtask

  // Instruction-level reference: what an instruction should do, not how
  task automatic model(input logic [31:0] inst, input logic z,
                       output int cyc, output logic [9:0] e_rw, output logic [9:0] e_mw,
                       output logic [9:0] e_pc, output logic [9:0] e_ill,
                       output logic op_ok, output logic [2:0] e_op, output logic e_ez,
                       output logic wr, output logic [1:0] e_rd, output logic [1:0] e_m2r);
    logic [5:0] op;
    logic [5:0] fn;
    logic       mwr, jump, ill;
    logic [9:0] last;
    op = inst[31:26];
    fn = inst[5:0];
    cyc = 2; wr = 0; mwr = 0; jump = 0; ill = 0;
    op_ok = 0; e_op = 3'b010; e_ez = 0; e_rd = 2'b00; e_m2r = 2'b00;
    case (op)
      6'b100011: begin cyc = 5; wr = 1; e_m2r = 2'b01; op_ok = 1; end
      6'b101011: begin cyc = 4; mwr = 1; op_ok = 1; end
      6'b000000: begin
        cyc = 4; wr = 1; e_rd = 2'b01; op_ok = 1;
        case (fn)
          6'b100000: e_op = 3'b010;
          6'b100010: e_op = 3'b110;
          6'b100100: e_op = 3'b000;
          6'b100101: e_op = 3'b001;
          6'b100110: e_op = 3'b011;
          6'b100111: e_op = 3'b100;
          6'b101010: e_op = 3'b111;
          6'b000010: e_op = 3'b101;
          default: begin cyc = 3; wr = 0; e_rd = 2'b00; op_ok = 0; ill = 1; end
        endcase
      end
      6'b000100: begin cyc = 3; jump = z;  op_ok = 1; e_op = 3'b110; end
      6'b000101: begin cyc = 3; jump = !z; op_ok = 1; e_op = 3'b110; end
      6'b000010: begin cyc = 3; jump = 1; op_ok = 1; end
      6'b000011: begin cyc = 3; jump = 1; op_ok = 1; wr = 1; e_rd = 2'b10; e_m2r = 2'b10; end
      6'b001000: begin cyc = 4; wr = 1; op_ok = 1; e_op = 3'b010; end
      6'b001100: begin cyc = 4; wr = 1; op_ok = 1; e_op = 3'b000; e_ez = 1; end
      6'b001101: begin cyc = 4; wr = 1; op_ok = 1; e_op = 3'b001; e_ez = 1; end
      6'b001110: begin cyc = 4; wr = 1; op_ok = 1; e_op = 3'b011; e_ez = 1; end
      6'b001010: begin cyc = 4; wr = 1; op_ok = 1; e_op = 3'b111; end
      default:   begin cyc = 2; ill = 1; end
    endcase
    last  = 10'(1) << (cyc - 1);
    e_rw  = wr   ? last : '0;
    e_mw  = mwr  ? last : '0;
    e_ill = ill  ? last : '0;
    e_pc  = 10'(1) | (jump ? last : '0);
  endtask

  task automatic check_inst(input string tag, input logic [31:0] inst, input logic z);
    int         cyc;
    logic [9:0] e_rw, e_mw, e_pc, e_ill;
    logic       op_ok, e_ez, wr;
    logic [2:0] e_op;
    logic [1:0] e_rd, e_m2r;
    exec(inst, z);
    model(inst, z, cyc, e_rw, e_mw, e_pc, e_ill, op_ok, e_op, e_ez, wr, e_rd, e_m2r);
    chk($sformatf("%s.cycles inst=%h", tag, inst), 32'(n_cyc), 32'(cyc));
    chk($sformatf("%s.regwrite_mask", tag), 32'(m_rw), 32'(e_rw));
    chk($sformatf("%s.memwrite_mask", tag), 32'(m_mw), 32'(e_mw));
    chk($sformatf("%s.pc_we_mask", tag), 32'(m_pc), 32'(e_pc));
    chk($sformatf("%s.irwrite_mask", tag), 32'(m_ir), 32'd1);
    chk($sformatf("%s.illegal_mask", tag), 32'(m_ill), 32'(e_ill));
    if (op_ok && n_cyc >= 3) chk($sformatf("%s.alu_op", tag), 32'(t_op[2]), 32'(e_op));
    if (cyc >= 3 && n_cyc >= 3) chk($sformatf("%s.ext_zero", tag), 32'(t_ez[2]), 32'(e_ez));
    if (wr && n_cyc == cyc) begin
      chk($sformatf("%s.regdst", tag), 32'(t_rd[cyc-1]), 32'(e_rd));
      chk($sformatf("%s.memtoreg", tag), 32'(t_m2r[cyc-1]), 32'(e_m2r));
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        z;
    int          len;
    logic [24:0] seq;
  } vec_t;

  function automatic logic [24:0] sq(int a, int b, int c, int d, int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  vec_t vecs [11];

  initial begin
    logic [5:0]  ops  [12];
    logic [5:0]  fns  [9];
    logic [31:0] r;
    logic [5:0]  op, fn;

    vecs[0]  = '{"lw",      {6'b100011, 26'h0a5_0004}, 1'b0, 5, sq(0, 1, 2, 3, 4)};
    vecs[1]  = '{"sw",      {6'b101011, 26'h0a5_0008}, 1'b0, 4, sq(0, 1, 2, 5, 0)};
    vecs[2]  = '{"add",     {6'b000000, 20'h4a5c0, 6'b100000}, 1'b0, 4, sq(0, 1, 6, 7, 0)};
    vecs[3]  = '{"beq_z1",  {6'b000100, 26'h021_0003}, 1'b1, 3, sq(0, 1, 8, 0, 0)};
    vecs[4]  = '{"bne_z1",  {6'b000101, 26'h021_0003}, 1'b1, 3, sq(0, 1, 8, 0, 0)};
    vecs[5]  = '{"j",       {6'b000010, 26'h000_1000}, 1'b0, 3, sq(0, 1, 9, 0, 0)};
    vecs[6]  = '{"jal",     {6'b000011, 26'h000_2000}, 1'b0, 3, sq(0, 1, 12, 0, 0)};
    vecs[7]  = '{"addi",    {6'b001000, 26'h022_fffc}, 1'b0, 4, sq(0, 1, 10, 11, 0)};
    vecs[8]  = '{"ori",     {6'b001101, 26'h022_8000}, 1'b0, 4, sq(0, 1, 10, 11, 0)};
    vecs[9]  = '{"ill_op",  {6'b111111, 26'h3ff_ffff}, 1'b0, 2, sq(0, 1, 0, 0, 0)};
    vecs[10] = '{"ill_fn",  {6'b000000, 20'h4a5c0, 6'b111111}, 1'b0, 3, sq(0, 1, 6, 0, 0)};

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
            6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b001010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
            6'b100111, 6'b101010, 6'b000010, 6'b110011};

    // Reset: state and all write strobes forced low even with mem_ready=1
    rst = 1'b1; inst_in = '0; zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst.state", 32'(state_out), 32'd0);
    chk("rst.pc_we", 32'(pc_we), 32'd0);
    chk("rst.irwrite", 32'(IRWrite), 32'd0);
    chk("rst.regwrite", 32'(RegWrite), 32'd0);
    chk("rst.memwrite", 32'(MemWrite), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.state", 32'(state_out), 32'd0);

    // Directed table with explicit state sequences
    foreach (vecs[i]) begin
      exec(vecs[i].inst, vecs[i].z);
      chk($sformatf("vec_%s.len", vecs[i].name), 32'(n_cyc), 32'(vecs[i].len));
      for (int k = 0; k < vecs[i].len && k < n_cyc; k++)
        chk($sformatf("vec_%s.state%0d", vecs[i].name, k), 32'(t_st[k]),
            32'(vecs[i].seq[k*5 +: 5]));
      check_inst(vecs[i].name, vecs[i].inst, vecs[i].z);
    end

    // Randomized instructions against the reference model
    for (int it = 0; it < 150; it++) begin
      r  = $urandom();
      op = ops[$urandom_range(11, 0)];
      fn = fns[$urandom_range(8, 0)];
      if ($urandom_range(9, 0) == 0) op = r[31:26];
      check_inst("rnd", {op, r[19:0], fn}, 1'($urandom_range(1, 0)));
    end

    // IF stall: three cycles without mem_ready, then a single fetch strobe
    inst_in = {6'b000010, 26'h0};
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ifwait%0d.state", k), 32'(state_out), 32'd0);
      chk($sformatf("ifwait%0d.irwrite", k), 32'(IRWrite), 32'd0);
      chk($sformatf("ifwait%0d.pc_we", k), 32'(pc_we), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ifgo.irwrite", 32'(IRWrite), 32'd1);
    chk("ifgo.pc_we", 32'(pc_we), 32'd1);
    chk("ifgo.fetch_ctrl", 32'({MemRead, IorD, ALUSrcA, ALUSrcB, PCSource, ALU_operation}),
        32'({1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010}));
    @(posedge clk); #1;
    chk("ifgo.state", 32'(state_out), 32'd1);
    @(negedge clk);
    chk("id.irwrite", 32'(IRWrite), 32'd0);
    chk("id.alusrcb", 32'(ALUSrcB), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (state_out == 5'd0) break;
    end
    chk("ifwait.return", 32'(state_out), 32'd0);

    // MR stall: lw holds in MR with no register write until mem_ready
    inst_in = {6'b100011, 26'h0};
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mrwait%0d.state", k), 32'(state_out), 32'd3);
      @(negedge clk);
      chk($sformatf("mrwait%0d.regwrite", k), 32'(RegWrite), 32'd0);
      chk($sformatf("mrwait%0d.iord", k), 32'(IorD), 32'd1);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("mrgo.state", 32'(state_out), 32'd4);
    @(posedge clk); #1;
    chk("mrgo.return", 32'(state_out), 32'd0);

    // Reset mid-cycle while sw waits in MW: abandon immediately
    inst_in = {6'b101011, 26'h0};
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mw.state", 32'(state_out), 32'd5);
    @(negedge clk);
    chk("mw.memwrite", 32'(MemWrite), 32'd1);
    @(posedge clk); #1;
    chk("mw.hold", 32'(state_out), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("mwrst.state", 32'(state_out), 32'd0);
    chk("mwrst.memwrite", 32'(MemWrite), 32'd0);
    chk("mwrst.strobes", 32'({pc_we, IRWrite, RegWrite, illegal}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mwrst.after", 32'(state_out), 32'd0);
    check_inst("after_rst", {6'b000000, 20'h12345, 6'b101010}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
